// File: rtl/stream_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : stream_arb_mux
// Purpose  : N-channel valid/ready single-beat stream multiplexer with an
//            internal arbiter (fixed-priority or round-robin) and a
//            registered output stage that also reports the source channel.
// Ports    :
//   clk        - clock, all logic on the rising edge
//   rst        - asynchronous active-high reset
//   in_data    - N_CH packed channels, channel i at [i*WIDTH +: WIDTH]
//   in_valid   - per-channel valid
//   in_ready   - per-channel ready (one-hot or zero)
//   mode       - 0: fixed priority (highest index wins), 1: round-robin
//   out_data   - registered selected data
//   out_ch     - registered index of the source channel
//   out_valid  - output register holds a beat
//   out_ready  - consumer accepts the beat
// Revision : 1.0 - initial release
// ============================================================================
module stream_arb_mux #(
  parameter  int N_CH  = 3,
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  mode,
  output logic [WIDTH-1:0]      out_data,
  output logic [CW-1:0]         out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]    out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    ptr_q, ptr_d;     // last granted channel

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic             load_en;
  logic             any_valid;
  logic             take;
  logic [CW-1:0]    sel;
  logic [CW-1:0]    rr_ch;
  logic             rr_found;
  int               rr_idx;
  logic [WIDTH-1:0] sel_data;

  assign load_en   = !out_valid_q || out_ready;
  assign any_valid = |in_valid;
  assign take      = any_valid && load_en;

  always_comb begin : p_arb
    sel      = '0;
    rr_ch    = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    if (!mode) begin
      // Ascending scan: the last valid index seen is the highest one.
      for (int i = 0; i < N_CH; i++) begin
        if (in_valid[CW'(i)]) begin
          sel = CW'(i);
        end
      end
    end else begin
      // Search ptr+1 .. ptr+N_CH with wrap; ptr itself is visited last.
      // The wrap is a single subtraction, so indices >= N_CH never appear.
      for (int k = 1; k <= N_CH; k++) begin
        rr_idx = int'(ptr_q) + k;
        if (rr_idx >= N_CH) begin
          rr_idx = rr_idx - N_CH;
        end
        rr_ch = CW'(rr_idx);
        if (!rr_found && in_valid[rr_ch]) begin
          rr_found = 1'b1;
          sel      = rr_ch;
        end
      end
    end
  end

  // Ready never looks at in_data; gated by rst so no handshake is seen while
  // the block is held in reset.
  for (genvar g = 0; g < N_CH; g++) begin : g_ready
    assign in_ready[g] = take && !rst && (sel == CW'(g));
  end

  always_comb begin : p_sel_data
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel == CW'(i)) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output register next state
  // --------------------------------------------------------------------------
  always_comb begin : p_next
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      if (any_valid) begin
        out_data_d  = sel_data;
        out_ch_d    = sel;
        out_valid_d = 1'b1;
        // Tracked in both modes so a switch to round-robin resumes after
        // the most recent winner.
        ptr_d       = sel;
      end else begin
        // Idle: drop valid, keep the last beat's data/channel visible.
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : p_regs
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= CW'(N_CH - 1);   // first round-robin search starts at 0
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_arb_mux
// Purpose  : Scoreboard bench for stream_arb_mux (N_CH=3, WIDTH=8). Accepted
//            beats predicted by a spec-level model are queued; a monitor
//            pops and compares every beat the consumer takes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_arb_mux;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int CW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready;

  always #5 clk = ~clk;

  stream_arb_mux #(.N_CH(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct packed {
    logic [7:0]   ch;
    logic [W-1:0] d;
  } beat_t;

  beat_t sbq[$];
  int total = 0;
  int bad   = 0;

  // reference model state
  int           m_ptr;
  bit           m_ov;
  logic [W-1:0] m_last_d;
  int           m_last_ch;
  int           m_win;

  // random producer state
  logic [N-1:0]   cur_v;
  logic [N*W-1:0] cur_d;

  localparam logic [N*W-1:0] DATA = {8'hCC, 8'hBB, 8'hAA};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Winner by the arbitration rules; -1 when nothing is valid.
  function automatic int model_pick(input logic [N-1:0] v, input logic md, input int ptr);
    if (v == '0) return -1;
    if (!md) begin
      for (int i = N - 1; i >= 0; i--) if (v[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (ptr + k) % N;
        if (v[c]) return c;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr     = N - 1;
    m_ov      = 1'b0;
    m_last_d  = '0;
    m_last_ch = 0;
    m_win     = -1;
    cur_v     = '0;
    sbq.delete();
  endtask

  // One clock cycle; entered and left at posedge+1.
  task automatic cyc(input logic [N-1:0] v, input logic [N*W-1:0] d,
                     input logic md, input logic ordy);
    logic [N-1:0] er;
    bit           load;
    in_valid  = v;
    in_data   = d;
    mode      = md;
    out_ready = ordy;
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
    if (!m_ov) begin
      chk("hold_data", {24'b0, out_data}, {24'b0, m_last_d});
      chk("hold_ch", {30'b0, out_ch}, m_last_ch);
    end
    load  = !m_ov || ordy;
    m_win = load ? model_pick(v, md, m_ptr) : -1;
    er    = (m_win >= 0) ? N'(1 << m_win) : '0;
    chk("in_ready", {29'b0, in_ready}, {29'b0, er});
    if (m_win >= 0) begin
      sbq.push_back({8'(m_win), d[m_win*W +: W]});
      m_ptr     = m_win;
      m_ov      = 1'b1;
      m_last_d  = d[m_win*W +: W];
      m_last_ch = m_win;
    end else if (load) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Producers obey the hold rule but may legally withdraw a pending beat.
  task automatic rand_cycles(input int n, input int msel);
    logic md;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < N; i++) begin
        if (cur_v[i] && m_win != i) begin
          if ($urandom_range(9) == 0) cur_v[i] = 1'b0;
        end else begin
          cur_v[i] = ($urandom_range(99) < 60);
          cur_d[i*W +: W] = W'($urandom);
        end
      end
      md = (msel == 2) ? 1'($urandom_range(1)) : 1'(msel);
      cyc(cur_v, cur_d, md, ($urandom_range(99) < 70));
    end
  endtask

  // Reset asserted mid-cycle while the output register holds a beat.
  task automatic do_reset_mid();
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    in_valid  = '1;
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data", {24'b0, out_data}, 32'd0);
    chk("rst_ch", {30'b0, out_ch}, 32'd0);
    chk("rst_ready", {29'b0, in_ready}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every beat the consumer takes must match the queue head.
  initial begin : p_monitor
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        beat_t e;
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat actual_ch=%0d actual_data=%0h required=none t=%0t",
                   out_ch, out_data, $time);
        end else begin
          e = sbq.pop_front();
          chk("beat_ch", {30'b0, out_ch}, {24'b0, e.ch});
          chk("beat_data", {24'b0, out_data}, {24'b0, e.d});
        end
      end
    end
  end

  initial begin : p_stim
    rst       = 1'b1;
    in_valid  = '1;
    in_data   = DATA;
    mode      = 1'b0;
    out_ready = 1'b0;
    cur_d     = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_valid", {31'b0, out_valid}, 32'd0);
    chk("init_ready", {29'b0, in_ready}, 32'd0);
    chk("init_data", {24'b0, out_data}, 32'd0);
    rst = 1'b0;

    // fixed priority: highest index wins
    for (int k = 0; k < 4; k++) begin
      cyc(3'b111, DATA, 1'b0, 1'b1);
      chk("fp_ch", {30'b0, out_ch}, 32'd2);
      chk("fp_data", {24'b0, out_data}, 32'hCC);
    end
    cyc(3'b011, DATA, 1'b0, 1'b1);
    chk("fp_drop_ch", {30'b0, out_ch}, 32'd1);
    chk("fp_drop_data", {24'b0, out_data}, 32'hBB);

    // backpressure: everything stalls, output stable
    for (int k = 0; k < 4; k++) begin
      cyc(3'b011, DATA, 1'b0, 1'b0);
      chk("bp_data", {24'b0, out_data}, 32'hBB);
      chk("bp_ch", {30'b0, out_ch}, 32'd1);
    end
    cyc(3'b001, DATA, 1'b0, 1'b1);
    chk("bp_release_ch", {30'b0, out_ch}, 32'd0);
    cyc(3'b111, DATA, 1'b0, 1'b1);

    // reset mid-stream; first RR grant goes to lowest valid index
    do_reset_mid();
    cyc(3'b110, DATA, 1'b1, 1'b1);
    chk("rr_first_ch", {30'b0, out_ch}, 32'd1);

    // round-robin from reset, all valid
    do_reset_mid();
    for (int k = 0; k < 6; k++) begin
      cyc(3'b111, DATA, 1'b1, 1'b1);
      chk("rr_ch", {30'b0, out_ch}, k % 3);
      chk("rr_data", {24'b0, out_data}, 32'hAA + 32'h11 * (k % 3));
    end

    // sparse round-robin with wrap from ptr=2, then back to fixed
    cyc(3'b101, DATA, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc(3'b101, DATA, 1'b1, 1'b1);
      chk("sparse_ch", {30'b0, out_ch}, (k % 2) * 2);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(3'b101, DATA, 1'b0, 1'b1);
      chk("sparse_fp_ch", {30'b0, out_ch}, 32'd2);
    end

    // idle: valid drops, data holds
    for (int k = 0; k < 3; k++) cyc(3'b000, DATA, 1'b0, 1'b1);
    chk("idle_data", {24'b0, out_data}, 32'hCC);
    chk("idle_valid", {31'b0, out_valid}, 32'd0);

    // randomized traffic
    rand_cycles(300, 2);
    rand_cycles(200, 1);
    rand_cycles(200, 0);
    cyc(3'b111, DATA, 1'b1, 1'b1);
    do_reset_mid();
    rand_cycles(200, 2);

    // drain
    for (int k = 0; k < 4; k++) cyc(3'b000, DATA, 1'b0, 1'b1);
    chk("sb_empty", sbq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_arb_mux.md
# stream_arb_mux

Parametrised N-channel, valid/ready stream multiplexer with an internal arbiter and a registered output stage. It is the next-generation replacement for the fixed 3-input priority mux: channel count and data width are parameters, and arbitration runs in either fixed-priority or round-robin mode. It sits between several producer streams and a single consumer. Each transfer is a single beat, and the block reports which channel each output beat came from.

## Interface
- N_CH, 3, number of input channels (≥2)
- WIDTH, 8, data width per channel
- CW, $clog2(N_CH), channel-index width (derived; not overridden)

- clk  input  1  single clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N_CH  per-channel valid
- in_ready  output  N_CH  per-channel ready (one-hot or zero)
- mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin
- out_data  output  WIDTH  registered selected data
- out_ch  output  CW  registered index of the source channel
- out_valid  output  1  output register holds a beat
- out_ready  input  1  consumer accepts beat

## Operation
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- load_en = !out_valid || out_ready. Arbitration happens every cycle; a grant is issued only when load_en = 1.
- Fixed priority (mode=0): grant the highest index i with in_valid[i]=1.
- Round-robin (mode=1):
  - Search upward from ptr+1, wrapping modulo N_CH.
  - Grant the first valid channel found; ptr itself has lowest priority.
- in_ready[i] = grant[i] & load_en. It is combinational from in_valid, mode, ptr, out_valid and out_ready. It never depends on in_data.
- On a handshake (in_valid[i] & in_ready[i]):
  - out_data <= channel i data; out_ch <= i; out_valid <= 1.
  - ptr <= i, in both modes, so a switch to round-robin resumes after the last winner.
- When load_en = 1 and no channel is valid:
  - out_valid <= 0.
  - out_data, out_ch and ptr hold their values.
- When out_valid = 1 and out_ready = 0: the output register holds, and all in_ready = 0.
- Mode changes take effect in the same cycle's arbitration. There is no flush, and a beat already in the output register is unaffected.
- At most one input handshake per cycle. No beat is ever dropped or duplicated.
- Inputs must hold in_valid and in_data until accepted (AXI-stream rule). Deasserting in_valid before acceptance is legal; the block simply does not grant that channel.

## Timing
- Reset values (immediate on rst assertion, independent of clk):
  - out_valid = 0, out_data = 0, out_ch = 0.
  - ptr = N_CH-1, so the first round-robin search starts at channel 0.
  - in_ready = 0 while rst = 1.
- Reset mid-transfer discards the held beat. A beat handshaken in the cycle rst asserts is lost; this is acceptable.
- Latency: an input handshake in cycle n makes the beat visible on out_* in cycle n+1.
- Throughput: 1 beat/cycle when out_ready is held high.
- Backpressure: out_ready = 0 with out_valid = 1 stalls all inputs in the same cycle, combinationally.
- Simultaneous events: out_ready = 1 with a new grant in the same cycle replaces the beat back-to-back, with no bubble.
- Round-robin fairness: with all N_CH channels continuously valid and out_ready = 1, each channel is granted exactly once every N_CH cycles.
- Wrap-around: after ptr = N_CH-1 the search starts at 0. With CW bits and a non-power-of-2 N_CH, indices ≥ N_CH are never produced.

## Test plan
- Reset: assert rst mid-stream with out_valid = 1.
  - out_valid falls to 0 without a clock edge; out_data = 0, out_ch = 0, in_ready = 0.
  - After release, the first round-robin grant goes to the lowest valid index.
- Fixed priority, N_CH=3, WIDTH=8: in_data = {8'hCC, 8'hBB, 8'hAA}, all valid, mode=0, out_ready=1.
  - Beats out are CC, CC, CC… with out_ch = 2.
  - Drop in_valid[2]: next beat is BB, out_ch = 1.
- Round-robin, same data, mode=1, all valid, out_ready=1 from reset.
  - out_ch sequence 0,1,2,0,1,2 with data AA,BB,CC,AA,…, one per cycle, no bubbles.
- Backpressure: out_ready = 0 for 4 cycles while out_valid = 1.
  - out_data and out_ch stable; in_ready = 0.
  - On the out_ready rising edge, the new beat appears the following cycle and no beat is lost or duplicated (scoreboard compare).
- Sparse round-robin with wrap: only in_valid[0] and in_valid[2] set, ptr = 2.
  - Grants alternate 0,2,0,2; channel 1 is never granted.
  - Switch to mode=0 mid-stream: grants become 2,2,2 from that cycle.
- Idle: all in_valid = 0 with out_ready = 1.
  - out_valid drops to 0 one cycle after the last beat is accepted; out_data holds its last value.
